sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the CPU instruction-fetch requester and the data-access requester. Each requester uses a req / addr_ok / data_ok handshake.
- Sits between mycpu_top and the future AXI bridge or unified cache. It replaces the two independent inst/data SRAM ports whenever a single-ported backing memory is used.
- Exactly one transaction is outstanding at a time. The data side has priority, bounded by a starvation limit for instruction fetch.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 4, max consecutive data grants while inst_req is pending. 0 means pure data priority.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction request
- inst_wr  in  1  write flag; always 0 in practice, still passed through
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  ADDR_W  request address
- inst_wdata  in  DATA_W  write data
- inst_addr_ok  out  1  request accepted
- inst_data_ok  out  1  response valid
- inst_rdata  out  DATA_W  read data
- data_req, data_wr, data_size, data_addr, data_wdata  in  (same widths as inst_*)  data requester
- data_addr_ok, data_data_ok, data_rdata  out  (same widths as inst_*)  data responses
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_size  out  2  downstream size
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_addr_ok  in  1  downstream request accepted
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream read data

Behaviour:
- Clock and reset: single clock clk. Reset resetn is asynchronous, active-low.
- Reset values:
  - state=IDLE, owner=INST, starve_cnt=0.
  - mem_req=0; mem_wr, mem_size, mem_addr, mem_wdata all 0.
  - All *_addr_ok and *_data_ok outputs 0.
  - Reset mid-transaction abandons it immediately; no pulse is produced.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any req is high, choose a winner and latch its wr/size/addr/wdata into the mem_* registers. Set mem_req=1 and owner=winner, then go to ADDR next cycle.
  - Winner rule: data wins unless inst_req=1 and starve_cnt==STARVE_LIMIT with STARVE_LIMIT!=0; in that case inst wins.
  - starve_cnt on a data grant: increment (saturating at STARVE_LIMIT) if inst_req=1, otherwise clear to 0.
  - starve_cnt on an inst grant: clear to 0.
- ADDR:
  - mem_* outputs are held stable from registers.
  - Owner's addr_ok = mem_addr_ok, combinational, same cycle.
  - On mem_addr_ok: mem_req<=0. Go to DATA, or go straight to IDLE if mem_data_ok is also 1 that cycle (zero-latency slave).
- DATA:
  - Owner's data_ok = mem_data_ok, combinational. On mem_data_ok go to IDLE.
  - There is one idle bubble cycle between transactions.
- rdata: inst_rdata and data_rdata are both driven by mem_rdata at all times. Only the owner's data_ok qualifies it.
- The non-owner never sees addr_ok or data_ok.
- Requesters must hold req and payload until addr_ok. The arbiter uses only its latched copy, so a premature req drop does not corrupt the bus.
- mem_data_ok while in IDLE, or without a prior mem_addr_ok in ADDR, is a protocol violation. It is ignored: no pulse, no state change.
- Simultaneous inst_req and data_req in IDLE follow the winner rule above. The loser keeps waiting and may be granted in the next IDLE.
- Address translation (kseg mapping) is NOT done here; it stays upstream.

Decomposition:
- Shared header mycpu_bus_defs:
  - State encodings IDLE=2'd0, ADDR=2'd1, DATA=2'd2.
  - Owner encodings INST=1'b0, DATA=1'b1.
  - SIZE_BYTE/HALF/WORD constants.
- One sub-module, arb_prio_sel:
  - Holds starve_cnt and the winner logic.
  - Inputs: inst_req, data_req, grant strobe. Output: winner.
  - Leaves the top with the FSM, payload registers and response routing.

Test Plan:
- Only inst_req, addr 0xBFC00000, slave gives addr_ok 1 cycle and data_ok 2 cycles after mem_req -> mem_addr=0xBFC00000, inst_addr_ok and inst_data_ok each pulse once, inst_rdata=mem_rdata, data_* pulses stay 0.
- inst_req and data_req both high in the same cycle, data_wr=1, addr 0x80001000, wdata 0xDEADBEEF -> data served first (mem_wr=1, mem_wdata=0xDEADBEEF); inst served in the next transaction.
- data_req held continuously with inst_req also high, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,...; with STARVE_LIMIT=0 inst is never granted while data_req=1.
- Zero-latency slave, mem_addr_ok and mem_data_ok both high in the first ADDR cycle -> owner gets addr_ok and data_ok in the same cycle, FSM returns to IDLE, next grant one cycle later.
- resetn asserted low while in DATA -> all outputs 0 immediately (asynchronously); after release the FSM is in IDLE and a late mem_data_ok produces no pulse.
- Spurious mem_data_ok in IDLE, and mem_addr_ok held low for 10 cycles -> no pulses; mem_req and mem_addr stay stable all 10 cycles.

Source files
------------

// File: rtl/mycpu_bus_defs.sv
// mycpu_bus_defs: shared encodings for the sram-like bus arbiter and its helpers.
package mycpu_bus_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: data-priority winner select with a starvation counter for instruction fetch.
module arb_prio_sel
    import mycpu_bus_defs::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   inst_req,
    input  logic   data_req,
    input  logic   grant,
    output owner_e winner
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    // A limit of zero never forces an instruction grant.
    assign starved = inst_req && (STARVE_LIMIT != 0) && (starve_cnt == LIM);
    assign winner  = (data_req && !starved) ? OWN_DATA : OWN_INST;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            starve_cnt <= '0;
        else if (grant)
            starve_cnt <= (winner == OWN_DATA && inst_req)
                        ? ((starve_cnt == LIM) ? LIM : starve_cnt + 1'b1)
                        : '0;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like port between inst fetch and data access,
// one outstanding transaction at a time, data priority with bounded inst starvation.
module sram_like_arbiter
    import mycpu_bus_defs::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state, state_nx;
    owner_e     owner, winner;
    logic       grant, addr_hit, resp_hit;

    arb_prio_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk     (clk),
        .resetn  (resetn),
        .inst_req(inst_req),
        .data_req(data_req),
        .grant   (grant),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // mem_data_ok outside ADDR-with-accept or DATA is a protocol violation and is dropped.
    always_comb begin
        state_nx     = state;
        grant        = 1'b0;
        addr_hit     = (state == ST_ADDR) && mem_addr_ok;
        resp_hit     = mem_data_ok && ((state == ST_DATA) || addr_hit);
        inst_addr_ok = addr_hit && (owner == OWN_INST);
        data_addr_ok = addr_hit && (owner == OWN_DATA);
        inst_data_ok = resp_hit && (owner == OWN_INST);
        data_data_ok = resp_hit && (owner == OWN_DATA);
        case (state)
            ST_IDLE: begin
                grant    = inst_req || data_req;
                state_nx = grant ? ST_ADDR : ST_IDLE;
            end
            ST_ADDR: state_nx = addr_hit ? (mem_data_ok ? ST_IDLE : ST_DATA) : ST_ADDR;
            ST_DATA: state_nx = mem_data_ok ? ST_IDLE : ST_DATA;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner     <= OWN_INST;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant) begin
            owner     <= winner;
            mem_req   <= 1'b1;
            mem_wr    <= (winner == OWN_DATA) ? data_wr    : inst_wr;
            mem_size  <= (winner == OWN_DATA) ? data_size  : inst_size;
            mem_addr  <= (winner == OWN_DATA) ? data_addr  : inst_addr;
            mem_wdata <= (winner == OWN_DATA) ? data_wdata : inst_wdata;
        end else if (addr_hit) begin
            mem_req   <= 1'b0;
        end
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule
